// File: rtl/card_counter_multi.sv
// card_counter_multi: per-rank card tallies, running count and undo history
// for a blackjack counter. One command per cycle: shuffle, deck_add, undo or card.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   card_valid/rank     deal one card (1=A, 2..9, 10=ten-valued)
//   undo                retract the newest undoable card
//   deck_add            grow the shoe by one deck (empty shoe only)
//   shuffle             new shoe: clear tallies/history, keep deck
//   rank_sel            rank reported on rank_seen
//   deck,total,remain   shoe size, cards dealt, cards left
//   running_count       signed running count for SYSTEM
//   rank_seen           tally of rank_sel after this edge
//   hist_cnt            undoable entries held
//   reject              pulse: a card/undo/deck_add was refused
module card_counter_multi #(
  parameter int SYSTEM     = 0,
  parameter int MAX_DECKS  = 8,
  parameter int HIST_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        card_valid,
  input  logic [3:0]                  card_rank,
  input  logic                        undo,
  input  logic                        deck_add,
  input  logic                        shuffle,
  input  logic [3:0]                  rank_sel,
  output logic [7:0]                  deck,
  output logic [CNT_W-1:0]            total,
  output logic [CNT_W-1:0]            remain,
  output logic signed [CNT_W-1:0]     running_count,
  output logic [7:0]                  rank_seen,
  output logic [$clog2(HIST_DEPTH):0] hist_cnt,
  output logic                        reject
);

  localparam int PW = $clog2(HIST_DEPTH);

  typedef logic signed [CNT_W-1:0] cnt_t;

  localparam logic [PW:0]      HFULL = (PW+1)'(HIST_DEPTH);
  localparam logic [7:0]       DMAX  = 8'(MAX_DECKS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam cnt_t             P1    = cnt_t'(1);
  localparam cnt_t             P2    = cnt_t'(2);
  localparam cnt_t             M1    = -P1;
  localparam cnt_t             M2    = -P2;

  function automatic logic rank_ok(
    input logic [3:0] r
  );
    return (r >= 4'd1) && (r <= 4'd10);
  endfunction

  function automatic cnt_t weight(
    input logic [3:0] r
  );
    cnt_t w;
    w = '0;
    if (SYSTEM == 2) begin
      unique case (r)
        4'd2, 4'd3, 4'd7: w = P1;
        4'd4, 4'd5, 4'd6: w = P2;
        4'd9:             w = M1;
        4'd10:            w = M2;
        default:          w = '0;
      endcase
    end else if (SYSTEM == 1) begin
      unique case (r)
        4'd2, 4'd3, 4'd4,
        4'd5, 4'd6, 4'd7: w = P1;
        4'd8, 4'd9:       w = '0;
        default:          w = M1;
      endcase
    end else begin
      unique case (r)
        4'd2, 4'd3, 4'd4,
        4'd5, 4'd6:       w = P1;
        4'd7, 4'd8, 4'd9: w = '0;
        default:          w = M1;
      endcase
    end
    return w;
  endfunction

  // KO is unbalanced: it starts at 4 - 4*decks.
  function automatic cnt_t irc(
    input logic [7:0] d
  );
    cnt_t k;
    k = '0;
    if (SYSTEM == 1) begin
      k = cnt_t'(4) - cnt_t'({d, 2'b00});
    end
    return k;
  endfunction

  // 52*d as 32*d + 16*d + 4*d
  function automatic logic [CNT_W-1:0] cards_in(
    input logic [7:0] d
  );
    logic [13:0] n;
    n = {1'b0, d, 5'b0}
      + {2'b0, d, 4'b0}
      + {4'b0, d, 2'b0};
    return CNT_W'(n);
  endfunction

  // 8-bit tallies saturate at 255 even
  // when the nominal limit is larger.
  function automatic logic below_limit(
    input logic [3:0] r,
    input logic [7:0] t,
    input logic [7:0] d
  );
    logic [11:0] lim;
    lim = (r == 4'd10) ? {d, 4'b0}
                       : {2'b0, d, 2'b0};
    return (t != 8'hFF)
        && ({4'b0, t} < lim);
  endfunction

  logic [7:0]       deck_q, deck_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  cnt_t             rc_q, rc_d;
  logic [7:0]       tally_q [16];
  logic [7:0]       tally_d [16];
  logic [3:0]       hist_q [HIST_DEPTH];
  logic [3:0]       hist_d [HIST_DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW:0]      hcnt_q, hcnt_d;
  logic [7:0]       seen_q, seen_d;
  logic             reject_q, reject_d;

  logic          do_shuf;
  logic          do_add;
  logic          do_undo;
  logic          do_card;
  logic [PW-1:0] pop_ptr;
  logic [3:0]    pop_rank;
  logic          card_ok;

  // Only the highest-priority command acts.
  assign do_shuf = shuffle;
  assign do_add  = deck_add & ~shuffle;
  assign do_undo = undo & ~deck_add
                 & ~shuffle;
  assign do_card = card_valid & ~undo
                 & ~deck_add & ~shuffle;

  always_comb begin
    deck_d   = deck_q;
    total_d  = total_q;
    remain_d = remain_q;
    rc_d     = rc_q;
    tally_d  = tally_q;
    hist_d   = hist_q;
    wr_d     = wr_q;
    hcnt_d   = hcnt_q;
    reject_d = 1'b0;
    pop_ptr  = wr_q - PW'(1);
    pop_rank = hist_q[pop_ptr];
    // remain == 52*deck - total, so
    // remain != 0 means the shoe has room.
    card_ok  = rank_ok(card_rank)
            && below_limit(card_rank,
                 tally_q[card_rank], deck_q)
            && (remain_q != '0);

    unique case (1'b1)
      do_shuf: begin
        for (int i = 0; i < 16; i++) begin
          tally_d[i] = '0;
        end
        total_d  = '0;
        remain_d = cards_in(deck_q);
        rc_d     = irc(deck_q);
        wr_d     = '0;
        hcnt_d   = '0;
      end
      do_add: begin
        if ((total_q == '0)
            && (deck_q < DMAX)) begin
          deck_d   = deck_q + 8'd1;
          remain_d = remain_q
                   + CNT_W'(52);
          rc_d     = irc(deck_q + 8'd1);
        end else begin
          reject_d = 1'b1;
        end
      end
      do_undo: begin
        if (hcnt_q != '0) begin
          tally_d[pop_rank] =
            tally_q[pop_rank] - 8'd1;
          total_d  = total_q - ONE;
          remain_d = remain_q + ONE;
          rc_d     = rc_q - weight(pop_rank);
          wr_d     = pop_ptr;
          hcnt_d   = hcnt_q - (PW+1)'(1);
        end else begin
          reject_d = 1'b1;
        end
      end
      do_card: begin
        if (card_ok) begin
          tally_d[card_rank] =
            tally_q[card_rank] + 8'd1;
          total_d  = total_q + ONE;
          remain_d = remain_q - ONE;
          rc_d     = rc_q + weight(card_rank);
          // When full, this write lands on
          // the oldest entry.
          hist_d[wr_q] = card_rank;
          wr_d     = wr_q + PW'(1);
          if (hcnt_q != HFULL) begin
            hcnt_d = hcnt_q + (PW+1)'(1);
          end
        end else begin
          reject_d = 1'b1;
        end
      end
      default: ;
    endcase

    seen_d = rank_ok(rank_sel)
           ? tally_d[rank_sel] : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deck_q   <= '0;
      total_q  <= '0;
      remain_q <= '0;
      rc_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        tally_q[i] <= '0;
      end
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      wr_q     <= '0;
      hcnt_q   <= '0;
      seen_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      deck_q   <= deck_d;
      total_q  <= total_d;
      remain_q <= remain_d;
      rc_q     <= rc_d;
      tally_q  <= tally_d;
      hist_q   <= hist_d;
      wr_q     <= wr_d;
      hcnt_q   <= hcnt_d;
      seen_q   <= seen_d;
      reject_q <= reject_d;
    end
  end

  assign deck          = deck_q;
  assign total         = total_q;
  assign remain        = remain_q;
  assign running_count = rc_q;
  assign rank_seen     = seen_q;
  assign hist_cnt      = hcnt_q;
  assign reject        = reject_q;

endmodule

// File: tb/tb_card_counter_multi.sv
// Bench for card_counter_multi: four instances (Hi-Lo, KO, Omega II,
// Hi-Lo with 4-entry history and 2-deck max) share one stimulus stream.
module tb_card_counter_multi;

  localparam int N = 4;
  localparam int C_SYS [N] = '{0, 1, 2, 0};
  localparam int C_HD  [N] = '{16, 16, 16, 4};
  localparam int C_MAX [N] = '{8, 8, 8, 2};

  localparam logic [4:0] RS = 5'b10000;
  localparam logic [4:0] SH = 5'b01000;
  localparam logic [4:0] DA = 5'b00100;
  localparam logic [4:0] UN = 5'b00010;
  localparam logic [4:0] CV = 5'b00001;
  localparam logic [4:0] NO = 5'b00000;

  typedef struct packed {
    logic [7:0]  deck;
    logic [15:0] total;
    logic [15:0] remain;
    logic [15:0] rc;
    logic [7:0]  rs;
    logic [4:0]  hc;
    logic        rej;
  } snap_t;
  typedef snap_t [N-1:0] snapv_t;
  typedef logic [12:0] step_t;

  logic clk, rst, card_valid, undo, deck_add, shuffle;
  logic [3:0] card_rank, rank_sel;

  logic [7:0]  deck_o   [N];
  logic [15:0] total_o  [N];
  logic [15:0] remain_o [N];
  logic [15:0] rc_o     [N];
  logic [7:0]  rs_o     [N];
  logic [4:0]  hc_o     [N];
  logic        rej_o    [N];
  logic [4:0]  hc0, hc1, hc2;
  logic [2:0]  hc3;

  always_comb begin
    hc_o[0] = hc0;
    hc_o[1] = hc1;
    hc_o[2] = hc2;
    hc_o[3] = {2'b00, hc3};
  end

  card_counter_multi #(.SYSTEM(0), .MAX_DECKS(8), .HIST_DEPTH(16), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_rank(card_rank),
    .undo(undo), .deck_add(deck_add), .shuffle(shuffle), .rank_sel(rank_sel),
    .deck(deck_o[0]), .total(total_o[0]), .remain(remain_o[0]),
    .running_count(rc_o[0]), .rank_seen(rs_o[0]), .hist_cnt(hc0), .reject(rej_o[0]));
  card_counter_multi #(.SYSTEM(1), .MAX_DECKS(8), .HIST_DEPTH(16), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_rank(card_rank),
    .undo(undo), .deck_add(deck_add), .shuffle(shuffle), .rank_sel(rank_sel),
    .deck(deck_o[1]), .total(total_o[1]), .remain(remain_o[1]),
    .running_count(rc_o[1]), .rank_seen(rs_o[1]), .hist_cnt(hc1), .reject(rej_o[1]));
  card_counter_multi #(.SYSTEM(2), .MAX_DECKS(8), .HIST_DEPTH(16), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_rank(card_rank),
    .undo(undo), .deck_add(deck_add), .shuffle(shuffle), .rank_sel(rank_sel),
    .deck(deck_o[2]), .total(total_o[2]), .remain(remain_o[2]),
    .running_count(rc_o[2]), .rank_seen(rs_o[2]), .hist_cnt(hc2), .reject(rej_o[2]));
  card_counter_multi #(.SYSTEM(0), .MAX_DECKS(2), .HIST_DEPTH(4), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_rank(card_rank),
    .undo(undo), .deck_add(deck_add), .shuffle(shuffle), .rank_sel(rank_sel),
    .deck(deck_o[3]), .total(total_o[3]), .remain(remain_o[3]),
    .running_count(rc_o[3]), .rank_seen(rs_o[3]), .hist_cnt(hc3), .reject(rej_o[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  snapv_t sbq [$];

  int m_deck [N];
  int m_total [N];
  int m_remain [N];
  int m_rc [N];
  int m_hn [N];
  int m_rs [N];
  bit m_rej [N];
  int m_tally [N][16];
  int m_hist [N][16];

  function automatic int wgt(input int sys, input int r);
    if (sys == 2) begin
      if (r == 2 || r == 3 || r == 7) return 1;
      if (r >= 4 && r <= 6) return 2;
      if (r == 9) return -1;
      if (r == 10) return -2;
      return 0;
    end
    if (r == 1 || r == 10) return -1;
    if (r >= 2 && r <= ((sys == 1) ? 7 : 6)) return 1;
    return 0;
  endfunction

  function automatic int irc(input int sys, input int d);
    return (sys == 1) ? 4 - 4 * d : 0;
  endfunction

  function automatic step_t mk(input logic [4:0] c, input logic [3:0] r, input logic [3:0] s);
    return {c, r, s};
  endfunction

  // Drive one cycle, advance the reference model, queue its expectation.
  task automatic cyc(input step_t st);
    logic [4:0] c;
    int rk, sel, pr, lim;
    snapv_t e;
    c = st[12:8];
    rk = int'(st[7:4]);
    sel = int'(st[3:0]);
    rst = c[4]; shuffle = c[3]; deck_add = c[2]; undo = c[1]; card_valid = c[0];
    card_rank = st[7:4]; rank_sel = st[3:0];
    for (int i = 0; i < N; i++) begin
      m_rej[i] = 1'b0;
      if (c[4]) begin
        m_deck[i] = 0; m_total[i] = 0; m_remain[i] = 0; m_rc[i] = 0; m_hn[i] = 0;
        for (int j = 0; j < 16; j++) m_tally[i][j] = 0;
      end else if (c[3]) begin
        for (int j = 0; j < 16; j++) m_tally[i][j] = 0;
        m_total[i] = 0; m_hn[i] = 0;
        m_remain[i] = 52 * m_deck[i];
        m_rc[i] = irc(C_SYS[i], m_deck[i]);
      end else if (c[2]) begin
        if (m_total[i] == 0 && m_deck[i] < C_MAX[i]) begin
          m_deck[i]++; m_remain[i] += 52;
          m_rc[i] = irc(C_SYS[i], m_deck[i]);
        end else m_rej[i] = 1'b1;
      end else if (c[1]) begin
        if (m_hn[i] > 0) begin
          pr = m_hist[i][m_hn[i] - 1];
          m_hn[i]--; m_tally[i][pr]--; m_total[i]--; m_remain[i]++;
          m_rc[i] -= wgt(C_SYS[i], pr);
        end else m_rej[i] = 1'b1;
      end else if (c[0]) begin
        lim = (rk == 10) ? 16 * m_deck[i] : 4 * m_deck[i];
        if (lim > 255) lim = 255;
        if (rk >= 1 && rk <= 10 && m_tally[i][rk] < lim && m_total[i] < 52 * m_deck[i]) begin
          m_tally[i][rk]++; m_total[i]++; m_remain[i]--;
          m_rc[i] += wgt(C_SYS[i], rk);
          if (m_hn[i] == C_HD[i]) begin
            for (int j = 0; j < C_HD[i] - 1; j++) m_hist[i][j] = m_hist[i][j + 1];
            m_hist[i][C_HD[i] - 1] = rk;
          end else begin
            m_hist[i][m_hn[i]] = rk;
            m_hn[i]++;
          end
        end else m_rej[i] = 1'b1;
      end
      m_rs[i] = (sel >= 1 && sel <= 10) ? m_tally[i][sel] : 0;
      e[i].deck = 8'(m_deck[i]); e[i].total = 16'(m_total[i]);
      e[i].remain = 16'(m_remain[i]); e[i].rc = 16'(m_rc[i]);
      e[i].rs = 8'(m_rs[i]); e[i].hc = 5'(m_hn[i]); e[i].rej = m_rej[i];
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snapv_t s;
    for (int k = 0; k < 2; k++) begin
      cyc(mk(RS, 4'd0, 4'd1));
      s = sbq.pop_front();
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({deck_o[i], total_o[i], remain_o[i], rc_o[i], rs_o[i], hc_o[i], rej_o[i]} !== s[i]) begin
          failures++;
          $display("FAIL reset k=%0d u%0d got d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b want d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b",
            k, i, deck_o[i], total_o[i], remain_o[i], $signed(rc_o[i]), rs_o[i], hc_o[i], rej_o[i],
            s[i].deck, s[i].total, s[i].remain, $signed(s[i].rc), s[i].rs, s[i].hc, s[i].rej);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (deck_o[i] !== 8'd0 || total_o[i] !== 16'd0 || remain_o[i] !== 16'd0 || rc_o[i] !== 16'd0
          || rs_o[i] !== 8'd0 || hc_o[i] !== 5'd0 || rej_o[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_vals u%0d got d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b want all 0",
          i, deck_o[i], total_o[i], remain_o[i], $signed(rc_o[i]), rs_o[i], hc_o[i], rej_o[i]);
      end
    end
  endtask

  task automatic test_hilo();
    step_t st [$];
    snapv_t s;
    st = '{mk(RS, 4'd0, 4'd10), mk(DA, 4'd0, 4'd10), mk(CV, 4'd2, 4'd10),
           mk(CV, 4'd5, 4'd10), mk(CV, 4'd10, 4'd10), mk(CV, 4'd7, 4'd10)};
    foreach (st[k]) begin
      cyc(st[k]);
      s = sbq.pop_front();
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({deck_o[i], total_o[i], remain_o[i], rc_o[i], rs_o[i], hc_o[i], rej_o[i]} !== s[i]) begin
          failures++;
          $display("FAIL hilo k=%0d u%0d got d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b want d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b",
            k, i, deck_o[i], total_o[i], remain_o[i], $signed(rc_o[i]), rs_o[i], hc_o[i], rej_o[i],
            s[i].deck, s[i].total, s[i].remain, $signed(s[i].rc), s[i].rs, s[i].hc, s[i].rej);
        end
      end
    end
    checks++;
    if (total_o[0] !== 16'd4 || remain_o[0] !== 16'd48 || rc_o[0] !== 16'd1 || rs_o[0] !== 8'd1) begin
      failures++;
      $display("FAIL hilo_end got t=%0d r=%0d rc=%0d rs=%0d want 4/48/1/1",
        total_o[0], remain_o[0], $signed(rc_o[0]), rs_o[0]);
    end
  endtask

  task automatic test_ko();
    step_t st [$];
    snapv_t s;
    st = '{mk(RS, 4'd0, 4'd7), mk(DA, 4'd0, 4'd7), mk(DA, 4'd0, 4'd7)};
    for (int n = 0; n < 4; n++) st.push_back(mk(CV, 4'd7, 4'd7));
    foreach (st[k]) begin
      cyc(st[k]);
      s = sbq.pop_front();
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({deck_o[i], total_o[i], remain_o[i], rc_o[i], rs_o[i], hc_o[i], rej_o[i]} !== s[i]) begin
          failures++;
          $display("FAIL ko k=%0d u%0d got d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b want d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b",
            k, i, deck_o[i], total_o[i], remain_o[i], $signed(rc_o[i]), rs_o[i], hc_o[i], rej_o[i],
            s[i].deck, s[i].total, s[i].remain, $signed(s[i].rc), s[i].rs, s[i].hc, s[i].rej);
        end
      end
      if (k == 2) begin
        checks++;
        if (rc_o[1] !== 16'hFFFC || deck_o[1] !== 8'd2) begin
          failures++;
          $display("FAIL ko_irc got rc=%0d d=%0d want -4/2", $signed(rc_o[1]), deck_o[1]);
        end
      end
    end
    checks++;
    if (rc_o[1] !== 16'd0 || rs_o[1] !== 8'd4) begin
      failures++;
      $display("FAIL ko_end got rc=%0d rs=%0d want 0/4", $signed(rc_o[1]), rs_o[1]);
    end
  endtask

  task automatic test_omega();
    step_t st [$];
    snapv_t s;
    st = '{mk(RS, 4'd0, 4'd10), mk(DA, 4'd0, 4'd10), mk(CV, 4'd4, 4'd10),
           mk(CV, 4'd9, 4'd10), mk(CV, 4'd10, 4'd10)};
    for (int n = 0; n < 4; n++) st.push_back(mk(UN, 4'd0, 4'd10));
    foreach (st[k]) begin
      cyc(st[k]);
      s = sbq.pop_front();
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({deck_o[i], total_o[i], remain_o[i], rc_o[i], rs_o[i], hc_o[i], rej_o[i]} !== s[i]) begin
          failures++;
          $display("FAIL omega k=%0d u%0d got d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b want d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b",
            k, i, deck_o[i], total_o[i], remain_o[i], $signed(rc_o[i]), rs_o[i], hc_o[i], rej_o[i],
            s[i].deck, s[i].total, s[i].remain, $signed(s[i].rc), s[i].rs, s[i].hc, s[i].rej);
        end
      end
      if (k == 4) begin
        checks++;
        if (rc_o[2] !== 16'hFFFF) begin
          failures++;
          $display("FAIL omega_rc got %0d want -1", $signed(rc_o[2]));
        end
      end
      if (k == 7 || k == 8) begin
        checks++;
        if (total_o[2] !== 16'd0 || rc_o[2] !== 16'd0 || hc_o[2] !== 5'd0 || rej_o[2] !== (k == 8)) begin
          failures++;
          $display("FAIL omega_undo k=%0d got t=%0d rc=%0d h=%0d j=%0b want 0/0/0/%0b",
            k, total_o[2], $signed(rc_o[2]), hc_o[2], rej_o[2], (k == 8));
        end
      end
    end
  endtask

  task automatic test_limits();
    step_t st [$];
    snapv_t s;
    int i_a5, i_full, i_da, i_max;
    st = '{mk(RS, 4'd0, 4'd1), mk(DA, 4'd0, 4'd1)};
    for (int n = 0; n < 5; n++) st.push_back(mk(CV, 4'd1, 4'd1));
    i_a5 = st.size() - 1;
    for (int r = 2; r <= 9; r++)
      for (int n = 0; n < 4; n++) st.push_back(mk(CV, 4'(r), 4'd1));
    for (int n = 0; n < 16; n++) st.push_back(mk(CV, 4'd10, 4'd1));
    st.push_back(mk(CV, 4'd2, 4'd1));
    i_full = st.size() - 1;
    st.push_back(mk(DA, 4'd0, 4'd1));
    i_da = st.size() - 1;
    st.push_back(mk(CV, 4'd0, 4'd1));
    st.push_back(mk(CV, 4'd11, 4'd1));
    st.push_back(mk(SH, 4'd0, 4'd1));
    st.push_back(mk(DA, 4'd0, 4'd1));
    st.push_back(mk(DA, 4'd0, 4'd1));
    i_max = st.size() - 1;
    foreach (st[k]) begin
      cyc(st[k]);
      s = sbq.pop_front();
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({deck_o[i], total_o[i], remain_o[i], rc_o[i], rs_o[i], hc_o[i], rej_o[i]} !== s[i]) begin
          failures++;
          $display("FAIL limits k=%0d u%0d got d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b want d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b",
            k, i, deck_o[i], total_o[i], remain_o[i], $signed(rc_o[i]), rs_o[i], hc_o[i], rej_o[i],
            s[i].deck, s[i].total, s[i].remain, $signed(s[i].rc), s[i].rs, s[i].hc, s[i].rej);
        end
      end
      if (k == i_a5) begin
        checks++;
        if (rej_o[0] !== 1'b1 || total_o[0] !== 16'd4 || rs_o[0] !== 8'd4) begin
          failures++;
          $display("FAIL fifth_ace got j=%0b t=%0d rs=%0d want 1/4/4", rej_o[0], total_o[0], rs_o[0]);
        end
      end
      if (k == i_full) begin
        checks++;
        if (rej_o[0] !== 1'b1 || total_o[0] !== 16'd52 || remain_o[0] !== 16'd0) begin
          failures++;
          $display("FAIL card53 got j=%0b t=%0d r=%0d want 1/52/0", rej_o[0], total_o[0], remain_o[0]);
        end
      end
      if (k == i_da) begin
        checks++;
        if (rej_o[0] !== 1'b1 || deck_o[0] !== 8'd1) begin
          failures++;
          $display("FAIL deck_add_busy got j=%0b d=%0d want 1/1", rej_o[0], deck_o[0]);
        end
      end
      if (k == i_max) begin
        checks++;
        if (rej_o[3] !== 1'b1 || deck_o[3] !== 8'd2 || rej_o[0] !== 1'b0 || deck_o[0] !== 8'd3) begin
          failures++;
          $display("FAIL max_decks got u3 j=%0b d=%0d u0 j=%0b d=%0d want 1/2 0/3",
            rej_o[3], deck_o[3], rej_o[0], deck_o[0]);
        end
      end
    end
  endtask

  task automatic test_hist();
    step_t st [$];
    snapv_t s;
    logic [3:0] rk [6];
    rk = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10};
    st = '{mk(RS, 4'd0, 4'd2), mk(DA, 4'd0, 4'd2)};
    foreach (rk[n]) st.push_back(mk(CV, rk[n], 4'd2));
    for (int n = 0; n < 5; n++) st.push_back(mk(UN, 4'd0, 4'd2));
    foreach (st[k]) begin
      cyc(st[k]);
      s = sbq.pop_front();
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({deck_o[i], total_o[i], remain_o[i], rc_o[i], rs_o[i], hc_o[i], rej_o[i]} !== s[i]) begin
          failures++;
          $display("FAIL hist k=%0d u%0d got d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b want d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b",
            k, i, deck_o[i], total_o[i], remain_o[i], $signed(rc_o[i]), rs_o[i], hc_o[i], rej_o[i],
            s[i].deck, s[i].total, s[i].remain, $signed(s[i].rc), s[i].rs, s[i].hc, s[i].rej);
        end
      end
      if (k == 7) begin
        checks++;
        if (hc_o[3] !== 5'd4 || hc_o[0] !== 5'd6) begin
          failures++;
          $display("FAIL hist_full got u3 h=%0d u0 h=%0d want 4/6", hc_o[3], hc_o[0]);
        end
      end
      if (k == 11) begin
        checks++;
        if (total_o[3] !== 16'd2 || rc_o[3] !== 16'd2 || hc_o[3] !== 5'd0) begin
          failures++;
          $display("FAIL hist4_undo got t=%0d rc=%0d h=%0d want 2/2/0", total_o[3], $signed(rc_o[3]), hc_o[3]);
        end
      end
      if (k == 12) begin
        checks++;
        if (rej_o[3] !== 1'b1 || total_o[3] !== 16'd2 || rej_o[0] !== 1'b0 || total_o[0] !== 16'd1) begin
          failures++;
          $display("FAIL hist4_empty got u3 j=%0b t=%0d u0 j=%0b t=%0d want 1/2 0/1",
            rej_o[3], total_o[3], rej_o[0], total_o[0]);
        end
      end
    end
  endtask

  task automatic test_priority();
    step_t st [$];
    snapv_t s;
    st = '{mk(RS, 4'd0, 4'd3), mk(DA, 4'd0, 4'd3), mk(CV, 4'd2, 4'd3), mk(CV, 4'd3, 4'd3),
           mk(SH | CV | UN, 4'd4, 4'd4), mk(CV, 4'd5, 4'd5), mk(CV, 4'd6, 4'd5),
           mk(DA | UN | CV, 4'd7, 4'd7), mk(CV, 4'd8, 4'd8), mk(RS | CV, 4'd9, 4'd9),
           mk(DA, 4'd0, 4'd3), mk(CV, 4'd3, 4'd3), mk(CV, 4'd3, 4'd3), mk(CV, 4'd3, 4'd5),
           mk(NO, 4'd0, 4'd3), mk(UN, 4'd0, 4'd3), mk(NO, 4'd0, 4'd0)};
    foreach (st[k]) begin
      cyc(st[k]);
      s = sbq.pop_front();
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({deck_o[i], total_o[i], remain_o[i], rc_o[i], rs_o[i], hc_o[i], rej_o[i]} !== s[i]) begin
          failures++;
          $display("FAIL prio k=%0d u%0d got d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b want d=%0d t=%0d r=%0d rc=%0d rs=%0d h=%0d j=%0b",
            k, i, deck_o[i], total_o[i], remain_o[i], $signed(rc_o[i]), rs_o[i], hc_o[i], rej_o[i],
            s[i].deck, s[i].total, s[i].remain, $signed(s[i].rc), s[i].rs, s[i].hc, s[i].rej);
        end
      end
      if (k == 4) begin
        checks++;
        if (total_o[0] !== 16'd0 || deck_o[0] !== 8'd1 || remain_o[0] !== 16'd52
            || hc_o[0] !== 5'd0 || rej_o[0] !== 1'b0) begin
          failures++;
          $display("FAIL shuffle_wins got t=%0d d=%0d r=%0d h=%0d j=%0b want 0/1/52/0/0",
            total_o[0], deck_o[0], remain_o[0], hc_o[0], rej_o[0]);
        end
      end
      if (k == 7) begin
        checks++;
        if (rej_o[0] !== 1'b1 || total_o[0] !== 16'd2 || hc_o[0] !== 5'd2) begin
          failures++;
          $display("FAIL add_wins got j=%0b t=%0d h=%0d want 1/2/2", rej_o[0], total_o[0], hc_o[0]);
        end
      end
      if (k == 9) begin
        checks++;
        if (deck_o[1] !== 8'd0 || total_o[1] !== 16'd0 || rc_o[1] !== 16'd0 || remain_o[1] !== 16'd0) begin
          failures++;
          $display("FAIL rst_mid got d=%0d t=%0d rc=%0d r=%0d want 0/0/0/0",
            deck_o[1], total_o[1], $signed(rc_o[1]), remain_o[1]);
        end
      end
      if (k == 14) begin
        checks++;
        if (rs_o[0] !== 8'd3 || total_o[0] !== 16'd3) begin
          failures++;
          $display("FAIL b2b_sel got rs=%0d t=%0d want 3/3", rs_o[0], total_o[0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; card_valid = 1'b0; undo = 1'b0;
    deck_add = 1'b0; shuffle = 1'b0;
    card_rank = 4'd0; rank_sel = 4'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_hilo();
    test_ko();
    test_omega();
    test_limits();
    test_hist();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
